// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues word reads to instruction memory and
// buffers returned words with their PCs in an in-order queue feeding decode.
module instr_fetch_queue #(
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus8,
  output logic        InstrValid,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget
);
  localparam int            PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  logic [31:0]   fpc_p0;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   instr_q_p1 [QDEPTH];
  logic [31:0]   pc_q_p1    [QDEPTH];
  logic [31:0]   hold_instr_p1;
  logic [31:0]   hold_pc_p1;

  logic head_vld;
  logic accept;
  logic push;
  logic pop;
  logic flush;

  assign head_vld   = (count != '0);
  assign imem_req   = !reset && (count < FULL);
  assign imem_addr  = fpc_p0 & 32'hFFFF_FFFC;
  assign accept     = imem_req && imem_ready;
  assign InstrValid = head_vld && !reset;
  assign pop        = InstrValid && !stall;
  assign flush      = pop && PCSrc;
  // A redirect discards whatever word arrives in the same cycle.
  assign push       = accept && !flush;

  // Head outputs fall back to the last consumed entry once the queue drains.
  always_comb begin
    Instr   = '0;
    InstrPC = '0;
    if (!reset) begin
      if (head_vld) begin
        Instr   = instr_q_p1[rd_ptr];
        InstrPC = pc_q_p1[rd_ptr];
      end else begin
        Instr   = hold_instr_p1;
        InstrPC = hold_pc_p1;
      end
    end
  end

  assign PCPlus8 = InstrPC + 32'd8;

  // ---- p0: fetch PC, pointers and occupancy ----
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_p0 <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      fpc_p0 <= BranchTarget & 32'hFFFF_FFFC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
        fpc_p0 <= fpc_p0 + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- p1: queue storage ----
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q_p1[wr_ptr] <= imem_rdata;
      pc_q_p1[wr_ptr]    <= imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_instr_p1 <= '0;
      hold_pc_p1    <= '0;
    end else if (pop) begin
      hold_instr_p1 <= instr_q_p1[rd_ptr];
      hold_pc_p1    <= pc_q_p1[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: expected head PCs go into a scoreboard
// queue and a monitor compares every consumed head against it.
module tb_instr_fetch_queue;
  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus8;
  logic        InstrValid;
  logic        stall;
  logic        PCSrc;
  logic [31:0] BranchTarget;

  int checks;
  int errors;
  logic [31:0] exp_q [$];

  instr_fetch_queue #(.QDEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instr(Instr), .InstrPC(InstrPC), .PCPlus8(PCPlus8),
    .InstrValid(InstrValid), .stall(stall),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a word derived from its address in the same cycle.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
    tick();
    tick();
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && InstrValid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_head: got PC %h, expected none", InstrPC);
        end else begin
          e = exp_q.pop_front();
          chk("head_pc", InstrPC, e);
          chk("head_instr", Instr, e ^ 32'hA5A5_0000);
          chk("head_pcplus8", PCPlus8, e + 32'd8);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; PCSrc = 1'b0; BranchTarget = '0;
    fork monitor(); join_none
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_pc", InstrPC, 32'd0);

    // Streaming fetch, one instruction per cycle
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    reset = 1'b0; imem_ready = 1'b1;
    #1;
    chk("p1_req", {31'd0, imem_req}, 32'd1);
    chk("p1_addr", imem_addr, 32'h0);
    chk("p1_valid0", {31'd0, InstrValid}, 32'd0);
    tick();
    chk("p1_valid1", {31'd0, InstrValid}, 32'd1);
    chk("p1_instr", Instr, 32'hA5A5_0000);
    chk("p1_pc", InstrPC, 32'h0);
    chk("p1_pc8", PCPlus8, 32'h8);
    chk("p1_addr4", imem_addr, 32'h4);
    tick(); tick(); tick();
    imem_ready = 1'b0;
    tick();
    chk("p1_empty", {31'd0, InstrValid}, 32'd0);
    chk("p1_hold_pc", InstrPC, 32'hC);
    chk("p1_hold_instr", Instr, 32'hA5A5_000C);
    chk("p1_sb", exp_q.size(), 32'd0);

    // Stall until the queue saturates, then drain
    reset_seq();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b1;
    tick();
    chk("p2_req1", {31'd0, imem_req}, 32'd1);
    tick();
    chk("p2_full_req", {31'd0, imem_req}, 32'd0);
    chk("p2_instr", Instr, 32'hA5A5_0000);
    tick(); tick(); tick();
    chk("p2_full_req5", {31'd0, imem_req}, 32'd0);
    chk("p2_pc", InstrPC, 32'h0);
    stall = 1'b0;
    #1;
    chk("p2_full_pop_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("p2_pc4", InstrPC, 32'h4);
    chk("p2_req_back", {31'd0, imem_req}, 32'd1);
    tick();
    imem_ready = 1'b0;
    chk("p2_pc8", InstrPC, 32'h8);
    tick();
    chk("p2_empty", {31'd0, InstrValid}, 32'd0);
    chk("p2_sb", exp_q.size(), 32'd0);

    // Memory back-pressure: ready 1,0,0,1
    reset_seq();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    reset = 1'b0; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    chk("p3_addr_hold1", imem_addr, 32'h4);
    chk("p3_req_hold", {31'd0, imem_req}, 32'd1);
    tick();
    chk("p3_bubble", {31'd0, InstrValid}, 32'd0);
    chk("p3_addr_hold2", imem_addr, 32'h4);
    tick();
    imem_ready = 1'b1;
    chk("p3_bubble2", {31'd0, InstrValid}, 32'd0);
    chk("p3_addr_hold3", imem_addr, 32'h4);
    tick();
    chk("p3_valid", {31'd0, InstrValid}, 32'd1);
    chk("p3_pc4", InstrPC, 32'h4);
    tick();
    imem_ready = 1'b0;
    tick();
    chk("p3_sb", exp_q.size(), 32'd0);
    chk("p3_addr_end", imem_addr, 32'hC);

    // Taken branch at head PC 8 discards the same-cycle fetch of C
    reset_seq();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'h100);
    reset = 1'b0; imem_ready = 1'b1;
    tick(); tick(); tick();
    chk("p4_head8", InstrPC, 32'h8);
    chk("p4_addrC", imem_addr, 32'hC);
    PCSrc = 1'b1; BranchTarget = 32'h100;
    tick();
    PCSrc = 1'b0;
    #1;
    chk("p4_req", {31'd0, imem_req}, 32'd1);
    chk("p4_addr", imem_addr, 32'h100);
    chk("p4_flushed", {31'd0, InstrValid}, 32'd0);
    tick();
    imem_ready = 1'b0;
    chk("p4_pc100", InstrPC, 32'h100);
    chk("p4_valid", {31'd0, InstrValid}, 32'd1);
    tick();
    tick();
    chk("p4_empty", {31'd0, InstrValid}, 32'd0);
    chk("p4_sb", exp_q.size(), 32'd0);

    // PCSrc without a valid consumed instruction is ignored
    reset_seq();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    reset = 1'b0; imem_ready = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h200;
    tick();
    chk("p5_noflush_empty", imem_addr, 32'h0);
    imem_ready = 1'b1; stall = 1'b1;
    tick();
    chk("p5_valid", {31'd0, InstrValid}, 32'd1);
    tick();
    chk("p5_noflush_stall", imem_addr, 32'h8);
    chk("p5_full_req", {31'd0, imem_req}, 32'd0);
    PCSrc = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    tick(); tick();
    chk("p5_empty", {31'd0, InstrValid}, 32'd0);
    chk("p5_addr", imem_addr, 32'h8);
    chk("p5_sb", exp_q.size(), 32'd0);

    // Mid-stream reset with a full queue
    reset_seq();
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b1;
    tick(); tick();
    chk("p6_valid", {31'd0, InstrValid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("p6_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #1;
    chk("p6_valid0", {31'd0, InstrValid}, 32'd0);
    chk("p6_addr", imem_addr, 32'h0);
    chk("p6_req", {31'd0, imem_req}, 32'd1);
    chk("p6_pc0", InstrPC, 32'h0);

    // Fetch PC wrap through a misaligned branch target
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFC);
    imem_ready = 1'b1;
    tick();
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFF; imem_ready = 1'b0;
    tick();
    PCSrc = 1'b0; imem_ready = 1'b1;
    #1;
    chk("p7_addr_align", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_ready = 1'b0;
    chk("p7_wrap_fpc", imem_addr, 32'h0);
    chk("p7_pc", InstrPC, 32'hFFFF_FFFC);
    chk("p7_pc8", PCPlus8, 32'h4);
    tick();
    tick();
    chk("p7_sb", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the fetch PC and issues word reads to instruction memory over a req/ready handshake.
- Buffers returned words with their PCs in a small in-order queue and presents the head as Instr/InstrPC/PCPlus8 to decode.
- Redirects and flushes on a taken PCSrc from condition logic.

Parameters:
- QDEPTH, 2, queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request valid.
- imem_addr  output  32  word-aligned read address.
- imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- Instr  output  32  head-of-queue instruction to decoder/controller.
- InstrPC  output  32  address of Instr.
- PCPlus8  output  32  InstrPC + 8, ARM PC-read value.
- InstrValid  output  1  queue non-empty.
- stall  input  1  decode not consuming this cycle.
- PCSrc  input  1  taken branch/PC write from the current instruction.
- BranchTarget  input  32  new PC when PCSrc is taken.

Behaviour:
- Single clock domain; all state updates on the clk rising edge; reset is synchronous and active-high.
- Reset: fpc=RESET_PC, queue empty, count=0, rd/wr pointers=0. InstrValid=0, Instr=0, InstrPC=0, imem_req=0 during the reset cycle.
- imem_req = !reset && (count < QDEPTH). It is not a function of stall or pop, so there is no combinational path from stall.
- imem_addr = fpc, with bits [1:0] forced to 0. Addr and req stay stable while req=1 and imem_ready=0.
- Accept = imem_req && imem_ready. On accept: push {imem_rdata, fpc}; fpc += 4, wrapping modulo 2^32.
- Pop = InstrValid && !stall: advance rd pointer.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo QDEPTH.
- Head outputs are driven from queue storage; latency is accept→InstrValid = 1 cycle. PCPlus8 = InstrPC + 8, 32-bit wrap.
- Empty queue: InstrValid=0. Instr/InstrPC hold the last popped head value (not re-zeroed).
- Full queue (count==QDEPTH): imem_req=0 that cycle, even if a pop occurs; req reasserts the next cycle.
- Flush is qualified: flush = PCSrc && InstrValid && !stall. A PCSrc with no valid, consumed instruction is ignored.
- On flush: queue emptied (count=0, pointers=0), fpc=BranchTarget with bits [1:0] cleared. Any same-cycle accept is discarded: no push, fpc is not incremented. Flush has priority over push and pop.
- Next cycle after flush: imem_req=1, imem_addr=BranchTarget.
- Reset asserted mid-operation (including mid-flush or while req is pending on ready): same state as power-up reset next cycle. An accept in the reset cycle is ignored.
- Control states:
  - RUN: normal.
  - FLUSH is not a separate state; redirect completes in one cycle.
  - No outstanding-request tracking is needed, since data returns with ready.

Test Plan:
- Reset release, imem_ready=1 constant, stall=0, memory returns word=addr^32'hA5A5_0000: cycle 1 req=1 addr=0; cycle 2 InstrValid=1, Instr=32'hA5A5_0000, InstrPC=0, PCPlus8=8; consecutive PCs 0,4,8,C every cycle.
- stall=1 for 5 cycles from the first valid: count saturates at 2, imem_req drops to 0, Instr stays 32'hA5A5_0000. stall=0: heads PC 0, 4, 8 drain in order with no gap or duplicate.
- imem_ready toggled 1,0,0,1 with stall=0: addr held stable during ready=0. InstrValid low in the bubble cycles. Accepted PCs strictly 0,4,8.
- Head PC=8 with PCSrc=1, BranchTarget=32'h100, imem_ready=1 same cycle: fetched word at C discarded. Next cycle req addr=0x100; following cycle InstrPC=0x100, no PC C/10 ever valid.
- PCSrc=1 while InstrValid=0, or stall=1: no flush, fpc continues sequentially.
- Mid-stream reset=1 for one cycle while queue holds 2 entries: next cycle InstrValid=0, imem_addr=RESET_PC. fpc=32'hFFFF_FFFC wrap test: after accept fpc=0, PCPlus8 of that entry=4.
